// File: rtl/arm_pkg.sv
// Shared types and constants for the memory-stage SRAM bridge.
package arm_pkg;

   localparam int          DATA_W        = 32;
   localparam int          SRAM_DW       = 16;
   localparam int unsigned DEF_BASE_ADDR = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } sram_state_t;

   // Low half-word address of the 32-bit word holding byte_addr; wraps modulo 2^32.
   function automatic logic [31:0] lo_half_addr(input logic [31:0] byte_addr,
                                                input logic [31:0] base);
      return ((byte_addr - base) >> 2) << 1;
   endfunction

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Per-half hold timer: counts 0..WAIT_CYCLES-1 and parks on the terminal count.
module wait_counter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam int             CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0]  TC = CW'(WAIT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign done = (cnt_q == TC);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !done) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sram_controller.sv
// 32-bit load/store bridge to a 16-bit SRAM, done as two timed half-word accesses.
//
// state | meaning
// IDLE  | no transfer; accepts wr_en/rd_en (write wins)
// LO    | bits [15:0] on the bus for WAIT_CYCLES cycles
// HI    | bits [31:16] on the bus for WAIT_CYCLES cycles
// DONE  | ready high for the pipeline-advance edge; never retriggers
module sram_controller
   import arm_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          SRAM_AW     = 18
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic                rd_en,
   input  logic [DATA_W-1:0]   address,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready,
   output logic [SRAM_AW-1:0]  sram_addr,
   output logic                sram_we_n,
   output logic [SRAM_DW-1:0]  sram_dq_out,
   output logic                sram_dq_oe,
   input  logic [SRAM_DW-1:0]  sram_dq_in
);

   sram_state_t         state_q, state_d;
   logic                op_wr_q, op_wr_d;
   logic [SRAM_DW-1:0]  wdata_hi_q, wdata_hi_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
   logic [SRAM_DW-1:0]  dq_out_q, dq_out_d;

   logic                req;
   logic                in_xfer;
   logic                cnt_done;
   logic [31:0]         lo_addr;

   assign req     = wr_en | rd_en;
   assign in_xfer = (state_q == LO) || (state_q == HI);
   assign lo_addr = lo_half_addr(address, 32'(BASE_ADDR));

   wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_d != state_q),
      .enable (in_xfer),
      .done   (cnt_done)
   );

   always_comb begin
      state_d     = state_q;
      op_wr_d     = op_wr_q;
      wdata_hi_d  = wdata_hi_q;
      rdata_d     = rdata_q;
      sram_addr_d = sram_addr_q;
      dq_out_d    = dq_out_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d     = LO;
               op_wr_d     = wr_en;
               wdata_hi_d  = wdata[31:16];
               sram_addr_d = SRAM_AW'(lo_addr);
               if (wr_en) begin
                  dq_out_d = wdata[15:0];
               end
            end
         end
         LO: begin
            if (cnt_done) begin
               state_d     = HI;
               sram_addr_d = {sram_addr_q[SRAM_AW-1:1], 1'b1};
               if (op_wr_q) begin
                  dq_out_d = wdata_hi_q;
               end else begin
                  rdata_d[15:0] = sram_dq_in;
               end
            end
         end
         HI: begin
            if (cnt_done) begin
               state_d = DONE;
               if (!op_wr_q) begin
                  rdata_d[31:16] = sram_dq_in;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_wr_q     <= 1'b0;
         wdata_hi_q  <= '0;
         rdata_q     <= '0;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_wr_q     <= op_wr_d;
         wdata_hi_q  <= wdata_hi_d;
         rdata_q     <= rdata_d;
         sram_addr_q <= sram_addr_d;
         dq_out_q    <= dq_out_d;
      end
   end

   // Strobes decode from state so an async reset releases the bus immediately.
   assign sram_we_n   = ~(in_xfer & op_wr_q);
   assign sram_dq_oe  = in_xfer & op_wr_q;
   assign ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
   assign rdata       = rdata_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = dq_out_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural 16-bit SRAM model.
module tb_sram_controller;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready;
   logic [17:0] sram_addr;
   logic        sram_we_n;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;

   sram_controller #(
      .WAIT_CYCLES (W),
      .BASE_ADDR   (1024),
      .SRAM_AW     (18)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .address     (address),
      .wdata       (wdata),
      .rdata       (rdata),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_we_n   (sram_we_n),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_dq_in  (sram_dq_in)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:63];
   assign sram_dq_in = mem[sram_addr[5:0]];
   always @(posedge clk) begin
      if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
   end

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [17:0] lo_a;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vecs [8];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] sb_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic sb_check();
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL rdata: scoreboard empty at %0t", $time);
      end else begin
         chk("rdata", rdata, sb_q.pop_front());
      end
   endtask

   task automatic run_xfer(input vec_t v);
      logic hi;
      @(posedge clk); #1;
      wr_en = v.wr; rd_en = v.rd; address = v.addr; wdata = v.wdata;
      sb_q.push_back(v.exp_rdata);
      @(negedge clk);
      chk("ready_c0", 32'(ready), 32'd0);
      for (int c = 1; c <= 2*W; c++) begin
         @(negedge clk);
         hi = (c > W);
         chk("addr", 32'(sram_addr), hi ? 32'(v.lo_a) + 32'd1 : 32'(v.lo_a));
         chk("we_n", 32'(sram_we_n), v.wr ? 32'd0 : 32'd1);
         chk("oe", 32'(sram_dq_oe), v.wr ? 32'd1 : 32'd0);
         if (v.wr) chk("dq_out", 32'(sram_dq_out), hi ? 32'(v.wdata[31:16]) : 32'(v.wdata[15:0]));
         chk("ready_busy", 32'(ready), 32'd0);
      end
      @(negedge clk);
      chk("ready_done", 32'(ready), 32'd1);
      sb_check();
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      chk("we_n_idle", 32'(sram_we_n), 32'd1);
      chk("ready_idle", 32'(ready), 32'd1);
      @(negedge clk);
      chk("no_retrigger", 32'(ready), 32'd1);
      chk("addr_hold", 32'(sram_addr), 32'(v.lo_a) + 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2,       32'h0000_0000};
      vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,        18'd2,       32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 32'd1027, 32'h12345678, 18'd0,       32'hDEADBEEF};
      vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'h0,        18'd0,       32'h12345678};
      vecs[4] = '{1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, 18'd8,       32'h12345678};
      vecs[5] = '{1'b0, 1'b1, 32'd1043, 32'h0,        18'd8,       32'hCAFEF00D};
      vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'h0BADC0DE, 18'h3FFFE,   32'hCAFEF00D};
      vecs[7] = '{1'b0, 1'b1, 32'd1020, 32'h0,        18'h3FFFE,   32'h0BADC0DE};

      #3;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      #10 rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

      // Request held continuously: two back-to-back stores.
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'd1048; wdata = 32'h11112222;
      sb_q.push_back(32'h0BADC0DE);
      sb_q.push_back(32'h0BADC0DE);
      @(negedge clk);
      chk("b2b_c0", 32'(ready), 32'd0);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c == 5 || c == 11) begin
            chk("b2b_ready_done", 32'(ready), 32'd1);
            sb_check();
         end else begin
            chk("b2b_ready_busy", 32'(ready), 32'd0);
         end
         if (c == 7) begin
            chk("b2b_we_n_c7", 32'(sram_we_n), 32'd0);
            chk("b2b_addr_c7", 32'(sram_addr), 32'd12);
         end
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(negedge clk);
      chk("b2b_idle", 32'(ready), 32'd1);
      chk("b2b_mem12", 32'(mem[12]), 32'h2222);
      chk("b2b_mem13", 32'(mem[13]), 32'h1111);

      // Reset during the HI half of a store.
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'd1024; wdata = 32'h9999AAAA;
      for (int c = 0; c <= 3; c++) @(negedge clk);
      chk("mid_we_n_c3", 32'(sram_we_n), 32'd0);
      chk("mid_addr_c3", 32'(sram_addr), 32'd1);
      #2 rst_n = 1'b0;
      wr_en = 1'b0;
      #1;
      chk("arst_we_n", 32'(sram_we_n), 32'd1);
      chk("arst_oe", 32'(sram_dq_oe), 32'd0);
      chk("arst_addr", 32'(sram_addr), 32'd0);
      chk("arst_dq_out", 32'(sram_dq_out), 32'd0);
      chk("arst_rdata", rdata, 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_ready", 32'(ready), 32'd1);
         chk("post_rst_we_n", 32'(sram_we_n), 32'd1);
      end
      chk("post_rst_mem1", 32'(mem[1]), 32'h1234);
      chk("post_rst_mem0", 32'(mem[0]), 32'hAAAA);

      run_xfer('{1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF});

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL sb_leftover: %0d entries remain, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
